// File: rtl/decimal_key_arbiter_pkg.sv
// Shared types and helpers for the decimal key arbiter.
// Holds key count, BCD width, FSM states and the round-robin pick.
package decimal_key_arbiter_pkg;

    localparam int NUM_KEYS = 10;
    localparam int BCD_W    = 4;
    // Search window: the key vector concatenated with itself so a
    // rotation by ptr is a plain part-select.
    localparam int RR_W     = 2 * NUM_KEYS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESENT,
        ST_RELEASE
    } state_t;

    // First set bit of req searching upward from ptr with wrap.
    // Returns 0 when req is zero; caller qualifies with |req.
    function automatic logic [BCD_W-1:0] rr_pick(
        input logic [NUM_KEYS-1:0] req,
        input logic [BCD_W-1:0]    ptr
    );
        logic [RR_W-1:0]     dbl;
        logic [NUM_KEYS-1:0] rot;
        logic [BCD_W-1:0]    idx;
        logic                found;
        dbl   = {req, req};
        rot   = dbl[{1'b0, ptr} +: NUM_KEYS];
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = BCD_W'((int'(ptr) + k) % NUM_KEYS);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_dec_encoder.sv
// One-hot (10 lines) to BCD encoder; non-one-hot input gives 0.
// Ports: i_onehot[9:0] in, o_bcd[3:0] out.
module onehot_dec_encoder
    import decimal_key_arbiter_pkg::*;
(
    input  logic [NUM_KEYS-1:0] i_onehot,
    output logic [BCD_W-1:0]    o_bcd
);

    always_comb begin
        o_bcd = '0;
        case (i_onehot)
            10'b00_0000_0001: o_bcd = 4'd0;
            10'b00_0000_0010: o_bcd = 4'd1;
            10'b00_0000_0100: o_bcd = 4'd2;
            10'b00_0000_1000: o_bcd = 4'd3;
            10'b00_0001_0000: o_bcd = 4'd4;
            10'b00_0010_0000: o_bcd = 4'd5;
            10'b00_0100_0000: o_bcd = 4'd6;
            10'b00_1000_0000: o_bcd = 4'd7;
            10'b01_0000_0000: o_bcd = 4'd8;
            10'b10_0000_0000: o_bcd = 4'd9;
            default:          o_bcd = 4'd0;
        endcase
    end

endmodule

// File: rtl/decimal_key_arbiter.sv
// Round-robin, debounced decimal key arbiter with valid/ready digit out.
// Ports: clk, rst (sync, high), req[9:0], out_ready -> grant[9:0],
// digit[3:0], digit_valid, busy, glitch.
module decimal_key_arbiter
    import decimal_key_arbiter_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] req,
    input  logic                out_ready,
    output logic [NUM_KEYS-1:0] grant,
    output logic [BCD_W-1:0]    digit,
    output logic                digit_valid,
    output logic                busy,
    output logic                glitch
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_KEYS-1:0] r_grant;
    logic [BCD_W-1:0]    r_ptr;
    logic [7:0]          r_cnt;
    logic                r_glitch;

    logic [BCD_W-1:0]    w_digit;
    logic [BCD_W-1:0]    w_pick;
    logic                w_hit;
    logic                w_last;

    onehot_dec_encoder u_enc (
        .i_onehot (r_grant),
        .o_bcd    (w_digit)
    );

    assign w_pick = rr_pick(req, r_ptr);
    // Grant is one-hot, so masking req with it samples req[sel].
    assign w_hit  = |(req & r_grant);
    // cnt holds samples already seen; this sample completes the run.
    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|req) w_next = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!w_hit)     w_next = ST_IDLE;
                else if (w_last) w_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!w_hit && w_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        digit_valid = (r_state == ST_PRESENT);
        busy        = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_glitch <= 1'b0;
        end else begin
            r_glitch <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant <= NUM_KEYS'(1) << w_pick;
                        r_cnt   <= '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_hit) begin
                        r_glitch <= 1'b1;
                        r_grant  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) r_cnt <= '0;
                end
                ST_RELEASE: begin
                    if (w_hit) begin
                        r_cnt <= '0;
                    end else if (w_last) begin
                        r_grant <= '0;
                        r_ptr   <= (w_digit == 4'd9) ? 4'd0
                                                     : w_digit + 4'd1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant  = r_grant;
    assign digit  = w_digit;
    assign glitch = r_glitch;

endmodule

// File: tb/tb_decimal_key_arbiter.sv
// Scoreboard bench for decimal_key_arbiter (DEBOUNCE=4 main instance,
// DEBOUNCE=1 side instance for the single-sample boundary).
module tb_decimal_key_arbiter;

    logic       clk;
    logic       rst;
    logic [9:0] req;
    logic       out_ready;
    logic [9:0] grant;
    logic [3:0] digit;
    logic       digit_valid;
    logic       busy;
    logic       glitch;

    logic [9:0] req1;
    logic       rdy1;
    logic [9:0] g1;
    logic [3:0] d1;
    logic       v1;
    logic       b1;
    logic       gl1;

    int n_total = 0;
    int n_bad   = 0;
    int n_xfer  = 0;
    int n_push  = 0;
    int n_glitch = 0;
    int mptr    = 0;
    logic [3:0] sb[$];

    decimal_key_arbiter #(.DEBOUNCE(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .out_ready   (out_ready),
        .grant       (grant),
        .digit       (digit),
        .digit_valid (digit_valid),
        .busy        (busy),
        .glitch      (glitch)
    );

    decimal_key_arbiter #(.DEBOUNCE(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .req         (req1),
        .out_ready   (rdy1),
        .grant       (g1),
        .digit       (d1),
        .digit_valid (v1),
        .busy        (b1),
        .glitch      (gl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transfers happen on the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (!rst && glitch) n_glitch++;
        if (!rst && digit_valid && out_ready) begin
            n_xfer++;
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 1);
            else check("digit", 32'(digit), 32'(sb.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_model(input logic [9:0] keys, input int p);
        for (int k = 0; k < 10; k++) begin
            int i;
            i = (p + k) % 10;
            if (keys[4'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic wait_xfer(input int lim);
        int s;
        s = n_xfer;
        for (int c = 0; c < lim && n_xfer == s; c++) tick;
        check("xfer_seen", 32'(n_xfer - s), 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int c = 0; c < lim && busy; c++) tick;
        check("idle", 32'(busy), 0);
    endtask

    task automatic serve(input logic [9:0] keys);
        int w;
        w = rr_model(keys, mptr);
        sb.push_back(4'(w));
        n_push++;
        out_ready = 1'b1;
        req = keys;
        wait_xfer(40);
        req = '0;
        wait_idle(40);
        mptr = (w == 9) ? 0 : w + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", n_total);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        out_ready = 1'b0;
        req1 = '0;
        rdy1 = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        check("rst_grant", 32'(grant), 0);
        check("rst_digit", 32'(digit), 0);
        check("rst_valid", 32'(digit_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_glitch", 32'(glitch), 0);

        // DEBOUNCE=1: accepted on first DEBOUNCE-state sample.
        req1 = 10'h002;
        tick;
        check("d1_grant", 32'(g1), 32'(10'h002));
        check("d1_novalid", 32'(v1), 0);
        tick;
        check("d1_valid", 32'(v1), 1);
        check("d1_digit", 32'(d1), 1);
        tick;
        check("d1_drop", 32'(v1), 0);
        req1 = '0;
        tick;
        check("d1_idle", 32'(b1), 0);

        // Bounce on key 5: two high samples then low.
        out_ready = 1'b1;
        req = 10'h020;
        tick;
        tick;
        req = '0;
        tick;
        check("bn_glitch", 32'(glitch), 1);
        check("bn_grant", 32'(grant), 0);
        check("bn_busy", 32'(busy), 0);
        tick;
        check("bn_pulse", 32'(glitch), 0);

        // Contention: ptr still 0, so 0 then 9 alternately.
        repeat (4) serve(10'h201);

        // Single press of key 3 with exact timing.
        out_ready = 1'b1;
        sb.push_back(4'd3);
        n_push++;
        req = 10'h008;
        tick;
        check("sp_grant", 32'(grant), 32'(10'h008));
        check("sp_digit", 32'(digit), 3);
        check("sp_busy", 32'(busy), 1);
        repeat (3) begin
            tick;
            check("sp_novalid", 32'(digit_valid), 0);
        end
        tick;
        check("sp_valid", 32'(digit_valid), 1);
        check("sp_vdigit", 32'(digit), 3);
        tick;
        check("sp_drop", 32'(digit_valid), 0);
        check("sp_hold", 32'(grant), 32'(10'h008));
        check("sp_one", 32'(n_xfer), 32'(n_push));
        req = '0;
        repeat (3) begin
            tick;
            check("sp_rel_busy", 32'(busy), 1);
        end
        tick;
        check("sp_idle", 32'(busy), 0);
        check("sp_gclr", 32'(grant), 0);
        mptr = 4;

        // Wrap: serve 8 so ptr=9, then 9 is granted before 0.
        serve(10'h100);
        serve(10'h201);
        serve(10'h201);

        // Backpressure on key 7, line released while offered.
        out_ready = 1'b0;
        sb.push_back(4'd7);
        n_push++;
        req = 10'h080;
        for (int c = 0; c < 20 && !digit_valid; c++) tick;
        check("bp_valid", 32'(digit_valid), 1);
        req = '0;
        repeat (20) begin
            tick;
            check("bp_hold_v", 32'(digit_valid), 1);
            check("bp_hold_d", 32'(digit), 7);
        end
        out_ready = 1'b1;
        wait_xfer(5);
        check("bp_drop", 32'(digit_valid), 0);
        wait_idle(20);
        mptr = 8;

        // Reset while digit 2 is offered.
        out_ready = 1'b0;
        req = 10'h004;
        for (int c = 0; c < 20 && !digit_valid; c++) tick;
        check("rp_valid", 32'(digit_valid), 1);
        rst = 1'b1;
        out_ready = 1'b1;
        req = '0;
        tick;
        rst = 1'b0;
        check("rp_grant", 32'(grant), 0);
        check("rp_digit", 32'(digit), 0);
        check("rp_valid0", 32'(digit_valid), 0);
        check("rp_busy", 32'(busy), 0);
        tick;
        check("rp_quiet", 32'(digit_valid), 0);
        mptr = 0;
        serve(10'h201);

        check("sb_left", 32'(sb.size()), 0);
        check("n_xfer", 32'(n_xfer), 32'(n_push));
        check("n_glitch", 32'(n_glitch), 1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
